bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the calculator display path.

---
 rtl/bin2bcd_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 133 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Handshake and result bus of the sequential binary-to-BCD converter.
// master drives the request side, slave is the converter.
interface bin2bcd_if #(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned BCD_DIGITS = 5
);
    logic                      start;
    logic [BIN_W-1:0]          bin_in;
    logic                      busy;
    logic                      done;
    logic [4*BCD_DIGITS-1:0]   bcd_out;
    logic                      sign;
    logic                      overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, sign, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, sign, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and report the sign.
module bin2bcd_seq #(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned BCD_DIGITS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    bin2bcd_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               overflow_q, overflow_d;

    logic [BIN_W-1:0]   mag_c;
    logic               in_neg_c;
    logic [SR_W-1:0]    corr_c;

`ifdef BIN2BCD_SIGNED_EN
    assign in_neg_c = bus.bin_in[BIN_W-1];
    assign mag_c    = in_neg_c ? ({BIN_W{1'b0}} - bus.bin_in) : bus.bin_in;
`else
    assign in_neg_c = 1'b0;
    assign mag_c    = bus.bin_in;
`endif

    // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift
    always_comb begin
        corr_c = sr_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                corr_c[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sr_d    = {{BCD_W{1'b0}}, mag_c};
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = 1'b0;
                    neg_d   = in_neg_c;
                    busy_d  = 1'b1;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt_q != '0) begin
                    // Bit shifted out of the top digit means the value needs more digits
                    sr_d  = {corr_c[SR_W-2:0], 1'b0};
                    ovf_d = ovf_q | corr_c[SR_W-1];
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    bcd_d      = sr_q[SR_W-1 -: BCD_W];
                    sign_d     = neg_q;
                    overflow_d = ovf_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            neg_q      <= neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.sign     = sign_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: a 5-digit and a 4-digit instance share clock and reset.
module tb_bin2bcd_seq;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(16), .BCD_DIGITS(5)) a_if ();
    bin2bcd_if #(.BIN_W(16), .BCD_DIGITS(4)) b_if ();

    bin2bcd_seq #(.BIN_W(16), .BCD_DIGITS(5)) u_dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if.slave)
    );

    bin2bcd_seq #(.BIN_W(16), .BCD_DIGITS(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if.slave)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One conversion on the 5-digit unit; optional mid-run start pulse and reset, -100 disables them
    task automatic run_a(input logic [15:0] v, input int restart_at, input int reset_at,
                         output int lat, output int busy_cyc, output int dones);
        lat = -1; busy_cyc = 0; dones = 0;
        @(negedge clk);
        a_if.start  = 1'b1;
        a_if.bin_in = v;
        @(negedge clk);
        a_if.start  = 1'b0;
        a_if.bin_in = 16'hA5A5;
        for (int n = 0; n < 26; n++) begin
            if (n == restart_at) begin
                a_if.start  = 1'b1;
                a_if.bin_in = 16'd999;
            end else if (n == restart_at + 1) begin
                a_if.start  = 1'b0;
            end
            if (n == reset_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_busy", 32'(a_if.busy), 32'h0);
                check("abort_bcd",  32'(a_if.bcd_out), 32'h0);
            end
            if (n == reset_at + 3) reset_n = 1'b1;
            if (a_if.busy) busy_cyc++;
            if (a_if.done) begin
                dones++;
                if (lat < 0) lat = n;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_b(input logic [15:0] v);
        @(negedge clk);
        b_if.start  = 1'b1;
        b_if.bin_in = v;
        @(negedge clk);
        b_if.start  = 1'b0;
        for (int k = 0; k < 30 && !b_if.done; k++) @(negedge clk);
        check("b_done_seen", 32'(b_if.done), 32'h1);
        @(negedge clk);
    endtask

    int lat, bc, dn;
    int first_done, second_done;

    initial begin
        a_if.start = 1'b0; a_if.bin_in = '0;
        b_if.start = 1'b0; b_if.bin_in = '0;
        #1;
        check("rst_busy",     32'(a_if.busy),     32'h0);
        check("rst_done",     32'(a_if.done),     32'h0);
        check("rst_bcd",      32'(a_if.bcd_out),  32'h0);
        check("rst_sign",     32'(a_if.sign),     32'h0);
        check("rst_overflow", 32'(a_if.overflow), 32'h0);
        check("rst_bcd4",     32'(b_if.bcd_out),  32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_a(16'd0, -100, -100, lat, bc, dn);
        check("zero_bcd", 32'(a_if.bcd_out), 32'h00000);
        check("zero_ovf", 32'(a_if.overflow), 32'h0);
        check("zero_lat", 32'(lat), 32'd17);

        run_a(16'hFFFF, -100, -100, lat, bc, dn);
        check("max_bcd",   32'(a_if.bcd_out), 32'h65535);
        check("max_busy",  32'(bc), 32'd17);
        check("max_dones", 32'(dn), 32'd1);
        check("max_ovf",   32'(a_if.overflow), 32'h0);

        run_a(16'd12345, 5, -100, lat, bc, dn);
        check("restart_bcd",   32'(a_if.bcd_out), 32'h12345);
        check("restart_dones", 32'(dn), 32'd1);
        check("restart_busy",  32'(bc), 32'd17);

        run_a(16'd9999, -100, 8, lat, bc, dn);
        check("abort_dones", 32'(dn), 32'd0);
        run_a(16'd42, -100, -100, lat, bc, dn);
        check("post_abort_bcd", 32'(a_if.bcd_out), 32'h00042);

        run_a(16'd1234, -100, -100, lat, bc, dn);
        check("v1234_bcd", 32'(a_if.bcd_out), 32'h01234);
        run_a(16'd50000, -100, -100, lat, bc, dn);
        check("v50000_bcd", 32'(a_if.bcd_out), 32'h50000);

        run_b(16'hFFFF);
        check("d4_ovf_flag", 32'(b_if.overflow), 32'h1);
        check("d4_ovf_bcd",  32'(b_if.bcd_out),  32'h5535);
        run_b(16'd9999);
        check("d4_fit_flag", 32'(b_if.overflow), 32'h0);
        check("d4_fit_bcd",  32'(b_if.bcd_out),  32'h9999);

`ifdef BIN2BCD_SIGNED_EN
        run_a(16'h8000, -100, -100, lat, bc, dn);
        check("s_min_sign", 32'(a_if.sign), 32'h1);
        check("s_min_bcd",  32'(a_if.bcd_out), 32'h32768);
        run_a(16'hFFFF, -100, -100, lat, bc, dn);
        check("s_m1_sign", 32'(a_if.sign), 32'h1);
        check("s_m1_bcd",  32'(a_if.bcd_out), 32'h00001);
        run_a(16'hFF85, -100, -100, lat, bc, dn);
        check("s_m123_bcd", 32'(a_if.bcd_out), 32'h00123);
        run_a(16'h0000, -100, -100, lat, bc, dn);
        check("s_zero_sign", 32'(a_if.sign), 32'h0);
`else
        run_a(16'h8000, -100, -100, lat, bc, dn);
        check("u_8000_sign", 32'(a_if.sign), 32'h0);
        check("u_8000_bcd",  32'(a_if.bcd_out), 32'h32768);
`endif

        // start held high: back-to-back conversions one every 19 cycles
        first_done = -1; second_done = -1;
        @(negedge clk);
        a_if.start  = 1'b1;
        a_if.bin_in = 16'd7;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (a_if.done) begin
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
        end
        a_if.start = 1'b0;
        check("held_gap", 32'(second_done - first_done), 32'd19);
        check("held_bcd", 32'(a_if.bcd_out), 32'h00007);
        repeat (25) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
